// File: rtl/param_operand_queue.sv
// Parametrised ring-buffer operand queue: PUSH/REDUCE/POP/CLEAR with a sticky error code.
// Optional high-water-mark output max_count is enabled by defining OPQ_WATERMARK_EN.
module param_operand_queue #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   din,
   input  logic                op_valid,
   input  logic [2:0]          opcode,
   output logic [2*DATA_W-1:0] top_pair,
   output logic [DATA_W-1:0]   tail,
   output logic [CNT_W-1:0]    count,
   output logic                is_empty,
   output logic                is_full,
   output logic                is_err,
   output logic [1:0]          err_code
`ifdef OPQ_WATERMARK_EN
   ,
   output logic [CNT_W-1:0]    max_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = CNT_W + 1;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_PUSH   = 3'b001;
   localparam logic [2:0] OP_REDUCE = 3'b010;
   localparam logic [2:0] OP_POP    = 3'b011;
   localparam logic [2:0] OP_CLEAR  = 3'b100;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

   // base < DEPTH and off <= DEPTH, so one conditional subtraction always lands in range
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [CNT_W-1:0] off);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(base) + SUM_W'(off);
      if (sum >= SUM_W'(DEPTH)) begin
         wrap_add = PTR_W'(sum - SUM_W'(DEPTH));
      end else begin
         wrap_add = PTR_W'(sum);
      end
   endfunction

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [CNT_W-1:0]  count_r;
   logic              err_r;
   logic [1:0]        err_code_r;

   logic [PTR_W-1:0]  head_nxt_s;
   logic [CNT_W-1:0]  count_nxt_s;
   logic              err_nxt_s;
   logic [1:0]        err_code_nxt_s;
   logic              wr_en_s;
   logic              clr_s;
   logic [PTR_W-1:0]  wr_idx_s;
   logic [PTR_W-1:0]  second_idx_s;
   logic [PTR_W-1:0]  tail_idx_s;
   logic [DATA_W-1:0] hi_s;
   logic [DATA_W-1:0] lo_s;
   logic [DATA_W-1:0] tail_s;

   // REDUCE's new back slot (head+2 + count-2) coincides with PUSH's (head+count)
   assign wr_idx_s     = wrap_add(head_r, count_r);
   assign second_idx_s = wrap_add(head_r, CNT_W'(1));

   // Opcode decode and next-state computation
   always_comb begin
      head_nxt_s     = head_r;
      count_nxt_s    = count_r;
      err_nxt_s      = err_r;
      err_code_nxt_s = err_code_r;
      wr_en_s        = 1'b0;
      clr_s          = 1'b0;
      if (op_valid) begin
         case (opcode)
            OP_NOP: begin
               head_nxt_s = head_r;
            end
            OP_PUSH: begin
               if (count_r != CNT_W'(DEPTH)) begin
                  count_nxt_s = count_r + CNT_W'(1);
                  wr_en_s     = 1'b1;
               end else begin
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_OVF;
               end
            end
            OP_REDUCE: begin
               if (count_r >= CNT_W'(2)) begin
                  head_nxt_s  = wrap_add(head_r, CNT_W'(2));
                  count_nxt_s = count_r - CNT_W'(1);
                  wr_en_s     = 1'b1;
               end else begin
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_UDF;
               end
            end
            OP_POP: begin
               if (count_r != CNT_W'(0)) begin
                  head_nxt_s  = wrap_add(head_r, CNT_W'(1));
                  count_nxt_s = count_r - CNT_W'(1);
               end else begin
                  err_nxt_s      = 1'b1;
                  err_code_nxt_s = ERR_UDF;
               end
            end
            OP_CLEAR: begin
               head_nxt_s     = PTR_W'(0);
               count_nxt_s    = CNT_W'(0);
               err_nxt_s      = 1'b0;
               err_code_nxt_s = ERR_NONE;
               clr_s          = 1'b1;
            end
            default: begin
               err_nxt_s      = 1'b1;
               err_code_nxt_s = ERR_ILL;
            end
         endcase
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Queue state and storage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r     <= PTR_W'(0);
         count_r    <= CNT_W'(0);
         err_r      <= 1'b0;
         err_code_r <= ERR_NONE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= DATA_W'(0);
         end
      end else begin
         head_r     <= head_nxt_s;
         count_r    <= count_nxt_s;
         err_r      <= err_nxt_s;
         err_code_r <= err_code_nxt_s;
         if (wr_en_s) begin
            mem_r[wr_idx_s] <= din;
         end
      end
   end

`ifdef OPQ_WATERMARK_EN
   logic [CNT_W-1:0] max_r;

   // High-water mark of occupancy since reset or CLEAR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_r <= CNT_W'(0);
      end else if (clr_s) begin
         max_r <= CNT_W'(0);
      end else if (count_nxt_s > max_r) begin
         max_r <= count_nxt_s;
      end else begin
         max_r <= max_r;
      end
   end

   assign max_count = max_r;
`endif

   // Tail index only meaningful when non-empty; avoid count-1 underflow otherwise
   always_comb begin
      tail_idx_s = head_r;
      if (count_r != CNT_W'(0)) begin
         tail_idx_s = wrap_add(head_r, count_r - CNT_W'(1));
      end else begin
         tail_idx_s = head_r;
      end
   end

   // Slot masking so stale storage never reaches the outputs
   always_comb begin
      hi_s   = DATA_W'(0);
      lo_s   = DATA_W'(0);
      tail_s = DATA_W'(0);
      if (count_r >= CNT_W'(1)) begin
         hi_s   = mem_r[head_r];
         tail_s = mem_r[tail_idx_s];
      end else begin
         hi_s   = DATA_W'(0);
         tail_s = DATA_W'(0);
      end
      if (count_r >= CNT_W'(2)) begin
         lo_s = mem_r[second_idx_s];
      end else begin
         lo_s = DATA_W'(0);
      end
   end

   assign top_pair = {hi_s, lo_s};
   assign tail     = tail_s;
   assign count    = count_r;
   assign is_empty = (count_r == CNT_W'(0));
   assign is_full  = (count_r == CNT_W'(DEPTH));
   assign is_err   = err_r;
   assign err_code = err_code_r;

endmodule

// File: doc/param_operand_queue.md
Name: param_operand_queue

Overview:
- Parametrised, ring-buffer-based operand queue for the queue calculator; next generation of the fixed 5x8-bit operand queue.
- Presents the two front entries to the ALU as a concatenated pair and accepts the ALU result back as a single "reduce" operation.
- Adds configurable width and depth, a NOP and a CLEAR opcode, full and count status, and a sticky error code.

Parameters:
- DATA_W, 8, operand width in bits (>=1)
- DEPTH, 8, queue capacity in entries (>=2, any value; need not be a power of 2)
- CNT_W, $clog2(DEPTH+1), derived width of the occupancy count; not to be overridden

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  DATA_W  operand for PUSH, or ALU result for REDUCE
- op_valid  input  1  opcode qualifier; when 0 the cycle is a NOP
- opcode  input  3  operation select, sampled only when op_valid=1
- top_pair  output  2*DATA_W  {front, front+1}; invalid slots read as 0
- tail  output  DATA_W  most recently enqueued entry; 0 when empty
- count  output  CNT_W  current occupancy, 0..DEPTH
- is_empty  output  1  count==0
- is_full  output  1  count==DEPTH
- is_err  output  1  sticky error flag
- err_code  output  2  00 none, 01 overflow, 10 underflow, 11 illegal opcode

Behaviour:
- Reset: asynchronous, active-high. While asserted: head=0, count=0, is_err=0, err_code=00. All storage is reads-as-zero, so top_pair=0 and tail=0. is_empty=1, is_full=0.
- Storage: DEPTH x DATA_W array, head pointer, count. Entry i of the queue is at (head+i) mod DEPTH. Pointers wrap explicitly at DEPTH, so non-power-of-2 depths are supported.
- Outputs are combinational from registered state: a single-cycle op is visible immediately after the clock edge that performs it.
- Opcodes, 3'b000 NOP: no state change.
- Opcodes, 3'b001 PUSH: requires count<DEPTH. Writes din at (head+count) mod DEPTH; count+1.
- Opcodes, 3'b010 REDUCE: requires count>=2. Discards the two front entries, writes din at the new back; head+2 mod DEPTH, count-1.
  - Legal when full (net -1).
  - When count==2, the result becomes the sole entry, so top_pair={din,0}.
- Opcodes, 3'b011 POP: requires count>=1. head+1 mod DEPTH; count-1.
- Opcodes, 3'b100 CLEAR: head=0, count=0, is_err=0, err_code=00. Always legal.
- Opcodes, 3'b101..3'b111: illegal.
- Error rule: a failing or illegal op leaves the queue unchanged, sets is_err=1 and sets err_code to the code of that error.
  - A later error overwrites err_code.
  - is_err and err_code hold until rst or CLEAR; successful ops do not clear them.
- Overflow = PUSH when full. Underflow = REDUCE with count<2, or POP when empty.
- Slot masking:
  - top_pair upper half = entry 0 if count>=1, else 0.
  - top_pair lower half = entry 1 if count>=2, else 0.
  - tail = entry count-1 if count>=1, else 0.
  - Stale RAM contents are never exposed.
- Reset mid-operation: rst wins asynchronously; any op presented in the same cycle is lost.
- op_valid=0 with any opcode: NOP; no error, even for illegal codes.

Optional Feature:
- Macro: OPQ_WATERMARK_EN.
- When defined: adds output max_count [CNT_W], the high-water mark of count since the last rst or CLEAR.
  - Updates on the same edge as count, when the next count exceeds the current max_count.
  - Reset value 0; CLEAR sets it to 0.
- When not defined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 (DATA_W=8, DEPTH=8) -> count=3, top_pair=0x1122, tail=0x33, is_empty=0.
- From that state, REDUCE din=0x33+0x11=0x44 -> count=2, top_pair=0x3344, tail=0x44. Next, REDUCE din=0x77 -> count=1, top_pair=0x7700, tail=0x77.
- PUSH 8 values 0x01..0x08 -> is_full=1. Then:
  - PUSH 0x09 -> is_err=1, err_code=01, contents unchanged.
  - POP x3, then PUSH 0xA0, 0xA1, 0xA2 (wrap-around) -> top_pair=0x0405, tail=0xA2, count=8.
- Empty queue:
  - POP -> err_code=10, count=0.
  - PUSH 0x5A, then REDUCE -> err_code=10, count=1, top_pair=0x5A00.
  - opcode 3'b110 with op_valid=1 -> err_code=11.
  - CLEAR -> is_err=0, err_code=00, count=0, top_pair=0.
- DEPTH=5: PUSH x5, then POP/PUSH 12 times -> head wraps mod 5 and FIFO order is preserved. With OPQ_WATERMARK_EN, max_count=5; after CLEAR, max_count=0.
- Assert rst asynchronously mid-cycle while count=4 and a PUSH is pending -> outputs go to reset values before the next edge; the PUSH has no effect.
